hex_out_pio: RTL and testbench
==============================

// Module: hex_out_pio
// PURPOSE
//  Avalon-MM slave output PIO driving three active-low 7-segment digits (HEX0..HEX2).
//  Write-side counterpart of the HEX input PIO: software writes segment patterns over
//  the HPS lightweight bridge and the block drives them to the pins.
//  Adds atomic bit set/clear and per-digit hardware blinking from a programmable prescaler.
// PARAMETERS
//  DATA_W     21         segment bits (3 digits x 7); digit d = bits [7d+6:7d]
//  NDIGITS    3          digits, and width of BLINK_MASK
//  PERIOD_W   24         blink prescaler width
//  RESET_VAL  21'h1FFFFF DATA reset value (all segments off)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-high
//  address    in   3        register word offset
//  chipselect in   1        slave select
//  write_n    in   1        active-low write strobe
//  writedata  in   32       write data
//  readdata   out  32       registered read data
//  out_port   out  DATA_W   segment drive, active-low (1 = segment off)
// BEHAVIOUR
//  Interface: one clock `clk`; reset `reset` is asynchronous, active-high.
//  Register map, word offsets:
//   0 DATA     R/W  [DATA_W-1:0]
//   1 BLINK    R/W  [NDIGITS-1:0] per-digit blink enable
//   2 PERIOD   R/W  [PERIOD_W-1:0] half-period in clk cycles; 0 = blink off
//   4 OUTSET   W    DATA |= wd
//   5 OUTCLEAR W    DATA &= ~wd
//  Offsets 3, 6, 7 read 0; writes to them are ignored. OUTSET/OUTCLEAR read 0.
//  Write: chipselect & ~write_n; register updates on that clock edge. Unused upper wd bits ignored.
//  Read: readdata <= {zero-ext mux(address)} every clk (no chipselect qualification);
//   1-cycle latency; read of DATA in the cycle after a write returns the new value.
//  Reset: DATA=RESET_VAL, BLINK=0, PERIOD=0, cnt=0, phase=0, readdata=0, out_port=RESET_VAL.
//  Blink timer (FSM): IDLE (PERIOD==0: phase held 0, cnt=0) / RUN.
//   RUN: cnt decrements each clk; at cnt==0, cnt<=PERIOD-1 and phase toggles.
//   Write to PERIOD: cnt<=wd-1 (0 if wd==0), phase<=0; enter RUN if wd!=0, else IDLE.
//   PERIOD=1 -> phase toggles every cycle.
//  Output: out_port registered; digit d = 7'h7F when BLINK[d] & phase, else DATA digit d.
//   Output lags DATA/BLINK/phase by 1 clk (write->pins = 2 edges).
//  Reset asserted mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  HEX_OUT_PIO_BLINK_EN defined:
//   blink timer, BLINK and PERIOD registers present as above.
//  Not defined:
//   no timer logic; offsets 1, 2 read 0 and writes are ignored; out_port = registered DATA.
//   DATA/OUTSET/OUTCLEAR unchanged.
// STRUCTURE
//  Package hex_out_pio_pkg:
//   ADDR_DATA/BLINK/PERIOD/OUTSET/OUTCLEAR localparams, SEG_OFF = 7'h7F,
//   blink-state enum {IDLE, RUN}.
//  Sub-module hex_blink_timer (clk, reset, load, load_val, phase): prescaler + phase FF.
//   Instantiated only under HEX_OUT_PIO_BLINK_EN.
//  Top holds register file, set/clear logic, read mux and output register.
// TESTING
//  1 Reset: after reset -> out_port=21'h1FFFFF, readdata=0; read offset 0 -> 0x001FFFFF.
//  2 Write DATA=0x00040C0 -> out_port=0x00040C0 two edges later; readback 0x00040C0.
//    OUTSET 0x1 -> 0x00040C1; then OUTCLEAR 0x40 -> 0x0004081.
//  3 PERIOD=4, BLINK=3'b010 (BLINK_EN): bits[13:7] alternate DATA/7'h7F every 4 clks;
//    digits 0 and 2 are steady.
//  4 PERIOD rewritten to 0 mid-blink -> phase=0 next clk; all digits steady; PERIOD reads 0.
//  5 Reset pulsed while blinking and DATA=0 -> out_port=0x1FFFFF asynchronously;
//    BLINK and PERIOD read 0 after release.
//  6 Write/read offset 3, 6, 7 -> no state change, reads 0.
//    Without BLINK_EN: offsets 1, 2 read 0 and out_port never blanks.

Source files
------------

// File: rtl/hex_out_pio_pkg.sv
// hex_out_pio_pkg: shared register offsets, segment constants and the blink-timer state type.
package hex_out_pio_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned DIGIT_W = 7;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    // Active-low segments: all ones blanks a digit.
    localparam logic [DIGIT_W-1:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } blink_state_e;

endpackage

// File: rtl/hex_out_pio_if.sv
// hex_out_pio_if: Avalon-MM slave bus bundle for the HEX output PIO.
interface hex_out_pio_if
    import hex_out_pio_pkg::*;
;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (output address, chipselect, write_n, writedata, input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_out_pio_blink_timer.sv
// hex_blink_timer: programmable half-period prescaler driving the blink phase flip-flop.
module hex_blink_timer
    import hex_out_pio_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    output logic                phase
);

    blink_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] reload_q, reload_d;
    logic                phase_q, phase_d;

    // State, counter, reload value and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            phase_q  <= phase_d;
        end
    end

    // Count down in RUN and toggle phase on expiry; a load restarts from phase 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        phase_d  = phase_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    cnt_d   = reload_q - PERIOD_W'(1);
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            reload_d = load_val;
            phase_d  = 1'b0;
            if (load_val != '0) begin
                cnt_d   = load_val - PERIOD_W'(1);
                state_d = RUN;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/hex_out_pio.sv
// hex_out_pio: Avalon-MM output PIO for three active-low 7-segment digits with
// atomic set/clear and optional per-digit blinking (macro HEX_OUT_PIO_BLINK_EN).
module hex_out_pio
    import hex_out_pio_pkg::*;
#(
    parameter int unsigned       DATA_W    = 21,
    parameter int unsigned       NDIGITS   = 3,
    parameter int unsigned       PERIOD_W  = 24,
    parameter logic [DATA_W-1:0] RESET_VAL = 21'h1FFFFF
) (
    input  logic               clk,
    input  logic               reset,
    hex_out_pio_if.slave       bus,
    output logic [DATA_W-1:0]  out_port
);

    logic              wr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BUS_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] out_q, out_d;

    assign wr = bus.chipselect & ~bus.write_n;
    assign wd = bus.writedata[DATA_W-1:0];

    logic unused_wd;
    assign unused_wd = ^bus.writedata[BUS_W-1:DATA_W];

`ifdef HEX_OUT_PIO_BLINK_EN
    logic [NDIGITS-1:0]  blink_q, blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                phase;
    logic                period_load;

    assign period_load = wr && (bus.address == ADDR_PERIOD);

    hex_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (period_load),
        .load_val (bus.writedata[PERIOD_W-1:0]),
        .phase    (phase)
    );

    // Blink enable and period registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q  <= '0;
            period_q <= '0;
        end else begin
            blink_q  <= blink_d;
            period_q <= period_d;
        end
    end

    // Blink register writes.
    always_comb begin
        blink_d  = blink_q;
        period_d = period_q;
        if (wr && bus.address == ADDR_BLINK)  blink_d  = bus.writedata[NDIGITS-1:0];
        if (period_load)                      period_d = bus.writedata[PERIOD_W-1:0];
    end

    // Blank blinking digits during the active phase.
    always_comb begin
        out_d = data_q;
        for (int unsigned d = 0; d < NDIGITS; d++) begin
            if (blink_q[d] && phase) out_d[DIGIT_W*d +: DIGIT_W] = SEG_OFF;
        end
    end
`else
    localparam int unsigned unused_cfg = NDIGITS + PERIOD_W;

    // Without blinking the pins simply follow DATA.
    always_comb begin
        out_d = data_q;
    end
`endif

    // DATA register, read data and output pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
            rd_q   <= '0;
            out_q  <= RESET_VAL;
        end else begin
            data_q <= data_d;
            rd_q   <= rd_d;
            out_q  <= out_d;
        end
    end

    // Plain, set and clear writes to DATA.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default:       data_d = data_q;
            endcase
        end
    end

    // Unqualified read mux, zero-extended.
    always_comb begin
        rd_d = '0;
        case (bus.address)
            ADDR_DATA:   rd_d[DATA_W-1:0]   = data_q;
`ifdef HEX_OUT_PIO_BLINK_EN
            ADDR_BLINK:  rd_d[NDIGITS-1:0]  = blink_q;
            ADDR_PERIOD: rd_d[PERIOD_W-1:0] = period_q;
`endif
            default:     rd_d = '0;
        endcase
    end

    assign bus.readdata = rd_q;
    assign out_port     = out_q;

endmodule

// File: tb/tb_hex_out_pio.sv
// tb_hex_out_pio: directed self-checking bench for hex_out_pio (either build of HEX_OUT_PIO_BLINK_EN).
module tb_hex_out_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] out_port;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rv;

    hex_out_pio_if bus();

    hex_out_pio #(
        .DATA_W    (21),
        .NDIGITS   (3),
        .PERIOD_W  (24),
        .RESET_VAL (21'h1FFFFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Callers are always sitting just after a falling edge.
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        check("reset_out", {11'd0, out_port}, 32'h001FFFFF);
        check("reset_rd",  bus.readdata, 32'h0);
        reset = 1'b0;
        bus_rd(3'd0, rv);  check("rd_data_reset", rv, 32'h001FFFFF);

        // DATA write, pins lag by one more edge
        bus_wr(3'd0, 32'h000040C0);
        check("out_lag", {11'd0, out_port}, 32'h001FFFFF);
        bus_rd(3'd0, rv);  check("rd_data", rv, 32'h000040C0);
        check("out_data", {11'd0, out_port}, 32'h000040C0);
        bus_wr(3'd4, 32'hFFE00001);
        bus_rd(3'd0, rv);  check("rd_outset", rv, 32'h000040C1);
        check("out_outset", {11'd0, out_port}, 32'h000040C1);
        bus_wr(3'd5, 32'h00000040);
        bus_rd(3'd0, rv);  check("rd_outclear", rv, 32'h00004081);
        check("out_outclear", {11'd0, out_port}, 32'h00004081);

        // unmapped offsets
        bus_wr(3'd3, 32'hFFFFFFFF);
        bus_wr(3'd6, 32'hFFFFFFFF);
        bus_wr(3'd7, 32'hFFFFFFFF);
        bus_rd(3'd3, rv);  check("rd_off3", rv, 32'h0);
        bus_rd(3'd6, rv);  check("rd_off6", rv, 32'h0);
        bus_rd(3'd7, rv);  check("rd_off7", rv, 32'h0);
        bus_rd(3'd4, rv);  check("rd_off4", rv, 32'h0);
        bus_rd(3'd5, rv);  check("rd_off5", rv, 32'h0);
        bus_rd(3'd0, rv);  check("rd_data_kept", rv, 32'h00004081);

`ifdef HEX_OUT_PIO_BLINK_EN
        // blink digit 1 with half-period 4; blanked value = 0x4081 | 0x3F80
        bus_wr(3'd1, 32'h00000002);
        bus_wr(3'd2, 32'h00000004);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), {11'd0, out_port},
                  (((i - 1) / 4) % 2 == 1) ? 32'h00007F81 : 32'h00004081);
        end
        // phase is 1 here; stop the timer
        bus_wr(3'd2, 32'h0);
        check("stop_lag", {11'd0, out_port}, 32'h00007F81);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stopped_%0d", i), {11'd0, out_port}, 32'h00004081);
        end
        bus_rd(3'd2, rv);  check("rd_period0", rv, 32'h0);
        bus_rd(3'd1, rv);  check("rd_blink", rv, 32'h2);

        // reset while blinking all digits every cycle with DATA=0
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd1, 32'h7);
        bus_wr(3'd2, 32'h1);
        bus_rd(3'd2, rv);  check("rd_period1", rv, 32'h1);
        begin
            int k;
            k = 0;
            while (out_port !== 21'h0 && k < 6) begin
                @(negedge clk);
                k++;
            end
            check("blink_zero_seen", {11'd0, out_port}, 32'h0);
        end
`else
        // blink registers absent
        bus_wr(3'd1, 32'h00000007);
        bus_wr(3'd2, 32'h00000001);
        bus_rd(3'd1, rv);  check("rd_blink_absent", rv, 32'h0);
        bus_rd(3'd2, rv);  check("rd_period_absent", rv, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("steady_%0d", i), {11'd0, out_port}, 32'h00004081);
        end
        bus_wr(3'd0, 32'h0);
        @(negedge clk);
        check("out_zero", {11'd0, out_port}, 32'h0);
`endif

        // asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out", {11'd0, out_port}, 32'h001FFFFF);
        check("async_rst_rd",  bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(3'd1, rv);  check("rd_blink_rst", rv, 32'h0);
        bus_rd(3'd2, rv);  check("rd_period_rst", rv, 32'h0);
        bus_rd(3'd0, rv);  check("rd_data_rst", rv, 32'h001FFFFF);
        repeat (4) @(negedge clk);
        check("out_after_rst", {11'd0, out_port}, 32'h001FFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
